// File: rtl/xcv5_bootrom_arbiter_pkg.sv
// Shared types and constants for the boot ROM arbiter.
// BOOTROM_ARB_OUTREG_EN adds a response output register (latency 3).
package xcv5_bootrom_arbiter_pkg;

    typedef struct packed {
        logic clk;
        logic clk2x;
    } iu_clk_type;

`ifdef BOOTROM_ARB_OUTREG_EN
    localparam int BOOTROM_LAT = 3;
`else
    localparam int BOOTROM_LAT = 2;
`endif

    localparam int BOOTROM_ADDRMSB = 10;
    localparam int BOOTROM_IDW     = 2;

    typedef struct packed {
        logic                     req;
        logic [BOOTROM_ADDRMSB:0] addr;
    } bootrom_req_type;

    typedef struct packed {
        logic                   valid;
        logic [BOOTROM_IDW-1:0] id;
        logic [31:0]            data;
    } bootrom_rsp_type;

endpackage

// File: rtl/xcv5_bootrom_arbiter_if.sv
// Requester-side bus of the boot ROM arbiter.
// master = requesters, slave = arbiter.
interface xcv5_bootrom_arbiter_if #(
    parameter int NREQ    = 4,
    parameter int ADDRMSB = 10,
    parameter int IDW     = 2
);
    logic [NREQ-1:0]               req;
    logic [NREQ*(ADDRMSB+1)-1:0]   addr;
    logic [NREQ-1:0]               gnt;
    logic                          rsp_valid;
    logic [IDW-1:0]                rsp_id;
    logic [31:0]                   rsp_data;
    logic [NREQ-1:0]               pend;
    logic                          idle;

    modport master (
        output req, addr,
        input  gnt, rsp_valid, rsp_id, rsp_data, pend, idle
    );

    modport slave (
        input  req, addr,
        output gnt, rsp_valid, rsp_id, rsp_data, pend, idle
    );
endinterface

// File: rtl/bootrom_rr_pick.sv
// Combinational round-robin picker: first eligible bit after last.
// Shared by the BRAM-sharing controllers.
module bootrom_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] elig,
    input  logic [IDW-1:0]  last,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  winner
);
    logic           found;
    logic [IDW-1:0] idx;

    always_comb begin
        gnt    = '0;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(last) + k) % NREQ);
            if (!found && elig[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                winner   = idx;
            end
        end
    end
endmodule

// File: rtl/xcv5_bootrom_arbiter.sv
// Round-robin arbiter sharing one 2-cycle boot ROM among NREQ requesters.
// Define BOOTROM_ARB_OUTREG_EN for a registered response (latency 3).
module xcv5_bootrom_arbiter
    import xcv5_bootrom_arbiter_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int ADDRMSB = 10,
    parameter int IDW     = 2
) (
    input  iu_clk_type                   gclk,
    input  logic                         rstn,
    xcv5_bootrom_arbiter_if.slave        bus,
    output logic [ADDRMSB:0]             rom_addr,
    input  logic [31:0]                  rom_dout
);
    localparam int AW = ADDRMSB + 1;

    logic            clk;
    logic            unused_clk;
    logic [NREQ-1:0] pend, clr, elig, gnt;
    logic [IDW-1:0]  last, winner;
    logic [IDW-1:0]  id1, id2;
    logic            v1, v2, any_gnt;
    logic [AW-1:0]   addr_q, addr_sel;
    logic            rsp_v;
    logic [IDW-1:0]  rsp_i;

    assign clk        = gclk.clk2x;
    assign unused_clk = gclk.clk;

    always_comb begin
        clr = '0;
        for (int i = 0; i < NREQ; i++)
            if (rsp_v && rsp_i == IDW'(i)) clr[i] = 1'b1;
    end

    // Gating with rstn keeps gnt low while reset is held.
    assign elig = bus.req & ~(pend & ~clr) & {NREQ{rstn}};

    bootrom_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .elig   (elig),
        .last   (last),
        .gnt    (gnt),
        .winner (winner)
    );

    assign any_gnt = |gnt;

    always_comb begin
        addr_sel = '0;
        for (int i = 0; i < NREQ; i++)
            if (gnt[i]) addr_sel = bus.addr[i*AW +: AW];
    end

    assign rom_addr = any_gnt ? addr_sel : addr_q;
    assign bus.gnt  = gnt;
    assign bus.pend = pend;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend   <= '0;
            last   <= IDW'(NREQ - 1);
            addr_q <= '0;
            v1     <= 1'b0;
            id1    <= '0;
            v2     <= 1'b0;
            id2    <= '0;
        end else begin
            pend <= (pend & ~clr) | gnt;
            if (any_gnt) begin
                last   <= winner;
                addr_q <= addr_sel;
            end
            v1  <= any_gnt;
            id1 <= winner;
            v2  <= v1;
            id2 <= id1;
        end
    end

`ifdef BOOTROM_ARB_OUTREG_EN
    logic           v3;
    logic [IDW-1:0] id3;
    logic [31:0]    d3;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v3  <= 1'b0;
            id3 <= '0;
            d3  <= '0;
        end else begin
            v3  <= v2;
            id3 <= id2;
            d3  <= rom_dout;
        end
    end

    assign rsp_v        = v3;
    assign rsp_i        = id3;
    assign bus.rsp_data = d3;
    assign bus.idle     = ~any_gnt & ~v1 & ~v2 & ~v3;
`else
    assign rsp_v        = v2;
    assign rsp_i        = id2;
    assign bus.rsp_data = rom_dout;
    assign bus.idle     = ~any_gnt & ~v1 & ~v2;
`endif

    assign bus.rsp_valid = rsp_v;
    assign bus.rsp_id    = rsp_i;
endmodule
